// File: rtl/pipe_ctrl_regs.sv
// pipe_ctrl_regs: PC register plus IF/ID and ID/EX pipeline registers for the
// 5-stage RVX10-P core. They obey the hazard unit's stallF/stallD/flushE and the
// branch flushD, and return MemReadE/RdE to the hazard unit every cycle.
// Optional build macro PIPE_PERF_CNT_EN adds stall/bubble/squash event counters.
module pipe_ctrl_regs #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [31:0]       InstrF,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic              RegWriteD,
  input  logic              MemReadD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic [3:0]        ALUCtrlD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  output logic [XLEN-1:0]   PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic              ValidD,
  output logic              RegWriteE,
  output logic              MemReadE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              ValidE,
  output logic [3:0]        ALUCtrlE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       squash_cnt
`endif
);

  // Fetch stage: PC holds while the hazard unit stalls fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (!stallF) begin
      PCF <= PCNextF;
    end
  end

  // IF/ID boundary: a squash beats a stall, so a taken branch kills a stalled instruction.
  always_ff @(posedge clk) begin
    if (reset || flushD) begin
      InstrD <= NOP_INSTR;
      PCD    <= '0;
      ValidD <= 1'b0;
    end else if (!stallD) begin
      InstrD <= InstrF;
      PCD    <= PCF;
      ValidD <= 1'b1;
    end
  end

  // ID/EX boundary: a bubble zeroes everything, including RdE and MemReadE, so the
  // hazard unit cannot re-trigger a load-use stall off the bubble itself.
  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      RegWriteE <= 1'b0;
      MemReadE  <= 1'b0;
      MemWriteE <= 1'b0;
      BranchE   <= 1'b0;
      JumpE     <= 1'b0;
      ValidE    <= 1'b0;
      ALUCtrlE  <= '0;
      Rs1E      <= '0;
      Rs2E      <= '0;
      RdE       <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      ImmExtE   <= '0;
      PCE       <= '0;
    end else begin
      RegWriteE <= RegWriteD;
      MemReadE  <= MemReadD;
      MemWriteE <= MemWriteD;
      BranchE   <= BranchD;
      JumpE     <= JumpD;
      ValidE    <= ValidD;
      ALUCtrlE  <= ALUCtrlD;
      Rs1E      <= Rs1D;
      Rs2E      <= Rs2D;
      RdE       <= RdD;
      RD1E      <= RD1D;
      RD2E      <= RD2D;
      ImmExtE   <= ImmExtD;
      PCE       <= PCD;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Event counters: decode stalls, execute bubbles, and squashes of real instructions.
  // All three wrap naturally from 2^32-1 to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      squash_cnt <= '0;
    end else begin
      if (stallD && !flushD) stall_cnt  <= stall_cnt + 32'd1;
      if (flushE)            bubble_cnt <= bubble_cnt + 32'd1;
      if (flushD && ValidD)  squash_cnt <= squash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs: reset, free run, load-use stall, stall/flush
// priorities, reset during stall, and (with PIPE_PERF_CNT_EN) the event counters.
module tb_pipe_ctrl_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCNextF, InstrF;
  logic        stallF, stallD, flushD, flushE;
  logic        RegWriteD, MemReadD, MemWriteD, BranchD, JumpD;
  logic [3:0]  ALUCtrlD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic [31:0] PCF, InstrD, PCD;
  logic        ValidD;
  logic        RegWriteE, MemReadE, MemWriteE, BranchE, JumpE, ValidE;
  logic [3:0]  ALUCtrlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt, squash_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl_regs dut (
    .clk(clk), .reset(reset), .PCNextF(PCNextF), .InstrF(InstrF),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .ALUCtrlD(ALUCtrlD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE), .ALUCtrlE(ALUCtrlE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stallF = 0; stallD = 0; flushD = 0; flushE = 0;
  endtask

  task automatic set_dec(input logic rw, input logic mr, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
    RegWriteD = rw; MemReadD = mr; MemWriteD = 0; BranchD = 0; JumpD = 0;
    ALUCtrlD = 4'd0; Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RD1D = 32'h1111_0000; RD2D = 32'h2222_0000; ImmExtD = imm;
  endtask

  task automatic check_reset_state(input string tag);
    n_chk++; if (PCF !== 32'h0) begin n_fail++; $display("FAIL %s_pcf: got %h want %h", tag, PCF, 32'h0); end
    n_chk++; if (InstrD !== 32'h13) begin n_fail++; $display("FAIL %s_instrd: got %h want %h", tag, InstrD, 32'h13); end
    n_chk++; if (PCD !== 32'h0) begin n_fail++; $display("FAIL %s_pcd: got %h want %h", tag, PCD, 32'h0); end
    n_chk++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL %s_validd: got %b want 0", tag, ValidD); end
    n_chk++; if ({RegWriteE, MemReadE, MemWriteE, BranchE, JumpE, ValidE} !== 6'b0) begin
      n_fail++; $display("FAIL %s_ectl: got %b want 000000", tag, {RegWriteE, MemReadE, MemWriteE, BranchE, JumpE, ValidE}); end
    n_chk++; if ({ALUCtrlE, Rs1E, Rs2E, RdE} !== 19'b0) begin
      n_fail++; $display("FAIL %s_eidx: got %h want 0", tag, {ALUCtrlE, Rs1E, Rs2E, RdE}); end
    n_chk++; if ({RD1E, RD2E, ImmExtE, PCE} !== 128'b0) begin
      n_fail++; $display("FAIL %s_edata: got %h want 0", tag, {RD1E, RD2E, ImmExtE, PCE}); end
  endtask

  // Reset held two cycles with junk on stall/flush/decode inputs.
  task automatic test_reset();
    reset = 1; stallF = 1; stallD = 1; flushD = 0; flushE = 0;
    PCNextF = 32'hDEAD_BEEC; InstrF = 32'hFFFF_FFFF;
    set_dec(1, 1, 5'd3, 5'd4, 5'd5, 32'h55);
    tick(); tick();
    check_reset_state("reset");
  endtask

  // addi x1,x0,5 fetched at 0x0 flows to D then E.
  task automatic test_free_run();
    reset = 0; clear_ctl();
    set_dec(0, 0, 0, 0, 0, 0);
    PCNextF = 32'h4; InstrF = 32'h0050_0093;
    tick();
    n_chk++; if (InstrD !== 32'h0050_0093) begin n_fail++; $display("FAIL fr_instrd: got %h want %h", InstrD, 32'h0050_0093); end
    n_chk++; if (PCD !== 32'h0) begin n_fail++; $display("FAIL fr_pcd: got %h want 0", PCD); end
    n_chk++; if (ValidD !== 1'b1) begin n_fail++; $display("FAIL fr_validd: got %b want 1", ValidD); end
    n_chk++; if (PCF !== 32'h4) begin n_fail++; $display("FAIL fr_pcf1: got %h want 4", PCF); end
    n_chk++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL fr_valide1: got %b want 0", ValidE); end
    set_dec(1, 0, 5'd0, 5'd0, 5'd1, 32'd5);
    PCNextF = 32'h8; InstrF = 32'h0000_0013;
    tick();
    n_chk++; if (RdE !== 5'd1) begin n_fail++; $display("FAIL fr_rde: got %0d want 1", RdE); end
    n_chk++; if (RegWriteE !== 1'b1) begin n_fail++; $display("FAIL fr_regwritee: got %b want 1", RegWriteE); end
    n_chk++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL fr_valide2: got %b want 1", ValidE); end
    n_chk++; if (ImmExtE !== 32'd5) begin n_fail++; $display("FAIL fr_imme: got %h want 5", ImmExtE); end
    n_chk++; if (PCE !== 32'h0) begin n_fail++; $display("FAIL fr_pce: got %h want 0", PCE); end
    n_chk++; if (PCF !== 32'h8) begin n_fail++; $display("FAIL fr_pcf2: got %h want 8", PCF); end
    n_chk++; if (PCD !== 32'h4) begin n_fail++; $display("FAIL fr_pcd2: got %h want 4", PCD); end
  endtask

  // lw x5,0(x1) then add x6,x5,x1 with a one-cycle load-use stall.
  task automatic test_load_use();
    clear_ctl();
    set_dec(0, 0, 0, 0, 0, 0);
    PCNextF = 32'hC; InstrF = 32'h0000_A283;
    tick();
    set_dec(1, 1, 5'd1, 5'd0, 5'd5, 32'd0);
    PCNextF = 32'h10; InstrF = 32'h0012_8333;
    tick();
    n_chk++; if (MemReadE !== 1'b1 || RdE !== 5'd5) begin n_fail++; $display("FAIL lu_loadE: got mr=%b rd=%0d want mr=1 rd=5", MemReadE, RdE); end
    set_dec(1, 0, 5'd5, 5'd1, 5'd6, 32'd0);
    stallF = 1; stallD = 1; flushE = 1;
    PCNextF = 32'h14; InstrF = 32'h0000_0013;
    tick();
    n_chk++; if (PCF !== 32'h10) begin n_fail++; $display("FAIL lu_pcf_hold: got %h want 10", PCF); end
    n_chk++; if (InstrD !== 32'h0012_8333 || PCD !== 32'hC) begin n_fail++; $display("FAIL lu_d_hold: got %h/%h want 00128333/c", InstrD, PCD); end
    n_chk++; if (MemReadE !== 1'b0 || RdE !== 5'd0 || ValidE !== 1'b0 || RegWriteE !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got mr=%b rd=%0d v=%b rw=%b want 0/0/0/0", MemReadE, RdE, ValidE, RegWriteE); end
    clear_ctl();
    PCNextF = 32'h14; InstrF = 32'h0040_0393;
    tick();
    n_chk++; if (Rs1E !== 5'd5 || Rs2E !== 5'd1 || RdE !== 5'd6) begin n_fail++; $display("FAIL lu_add_e: got rs1=%0d rs2=%0d rd=%0d want 5/1/6", Rs1E, Rs2E, RdE); end
    n_chk++; if (ValidE !== 1'b1 || PCE !== 32'hC) begin n_fail++; $display("FAIL lu_add_v: got v=%b pce=%h want 1/c", ValidE, PCE); end
    n_chk++; if (PCF !== 32'h14 || InstrD !== 32'h0040_0393 || PCD !== 32'h10) begin
      n_fail++; $display("FAIL lu_resume: got %h/%h/%h want 14/00400393/10", PCF, InstrD, PCD); end
  endtask

  // stallF alone: PC holds, IF/ID reloads.
  task automatic test_stallf_only();
    clear_ctl(); stallF = 1;
    PCNextF = 32'h18; InstrF = 32'h0080_0413;
    tick();
    n_chk++; if (PCF !== 32'h14) begin n_fail++; $display("FAIL sf_pcf: got %h want 14", PCF); end
    n_chk++; if (InstrD !== 32'h0080_0413 || PCD !== 32'h14) begin n_fail++; $display("FAIL sf_d: got %h/%h want 00800413/14", InstrD, PCD); end
  endtask

  // flushD and stallD together: flush wins.
  task automatic test_flush_priority();
    clear_ctl(); flushD = 1; stallD = 1;
    set_dec(1, 0, 5'd0, 5'd0, 5'd7, 32'd0);
    PCNextF = 32'h1C; InstrF = 32'h0123_4567;
    tick();
    n_chk++; if (InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== 32'h0) begin
      n_fail++; $display("FAIL fp_d: got %h/%b/%h want 13/0/0", InstrD, ValidD, PCD); end
    n_chk++; if (RdE !== 5'd7 || ValidE !== 1'b1) begin n_fail++; $display("FAIL fp_e: got rd=%0d v=%b want 7/1", RdE, ValidE); end
    n_chk++; if (PCF !== 32'h1C) begin n_fail++; $display("FAIL fp_pcf: got %h want 1c", PCF); end
  endtask

  // flushD and flushE together: both squash.
  task automatic test_flush_both();
    clear_ctl();
    PCNextF = 32'h20; InstrF = 32'h00C0_0493;
    tick();
    n_chk++; if (InstrD !== 32'h00C0_0493 || ValidD !== 1'b1) begin n_fail++; $display("FAIL fb_load: got %h/%b want 00c00493/1", InstrD, ValidD); end
    flushD = 1; flushE = 1;
    set_dec(1, 1, 5'd2, 5'd3, 5'd9, 32'h7);
    tick();
    n_chk++; if (InstrD !== 32'h13 || ValidD !== 1'b0) begin n_fail++; $display("FAIL fb_d: got %h/%b want 13/0", InstrD, ValidD); end
    n_chk++; if (ValidE !== 1'b0 || RdE !== 5'd0 || RegWriteE !== 1'b0 || MemReadE !== 1'b0) begin
      n_fail++; $display("FAIL fb_e: got v=%b rd=%0d rw=%b mr=%b want 0", ValidE, RdE, RegWriteE, MemReadE); end
  endtask

  // Reset asserted while the pipe is stalled clears everything.
  task automatic test_reset_in_stall();
    clear_ctl();
    PCNextF = 32'h24; InstrF = 32'h0100_0513;
    set_dec(1, 0, 5'd1, 5'd2, 5'd10, 32'h3);
    tick();
    stallF = 1; stallD = 1; reset = 1;
    tick();
    check_reset_state("rst_stall");
    reset = 0; clear_ctl();
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset = 1; clear_ctl(); set_dec(0, 0, 0, 0, 0, 0);
    PCNextF = 32'h0; InstrF = 32'h13;
    tick();
    reset = 0;
    n_chk++; if ({stall_cnt, bubble_cnt, squash_cnt} !== 96'b0) begin
      n_fail++; $display("FAIL pc_reset: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, squash_cnt); end
    for (int i = 0; i < 3; i++) begin
      clear_ctl(); tick();
      stallF = 1; stallD = 1; flushE = 1; tick();
    end
    for (int i = 0; i < 2; i++) begin
      clear_ctl(); tick();
      flushD = 1; tick();
    end
    clear_ctl();
    n_chk++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL pc_stall: got %0d want 3", stall_cnt); end
    n_chk++; if (bubble_cnt !== 32'd3) begin n_fail++; $display("FAIL pc_bubble: got %0d want 3", bubble_cnt); end
    n_chk++; if (squash_cnt !== 32'd2) begin n_fail++; $display("FAIL pc_squash: got %0d want 2", squash_cnt); end
    dut.stall_cnt = 32'hFFFF_FFFF;
    stallF = 1; stallD = 1; flushE = 1;
    tick();
    clear_ctl();
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL pc_wrap: got %h want 0", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_stallf_only();
    test_flush_priority();
    test_flush_both();
    test_reset_in_stall();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
